// File: rtl/rdm_pkg.sv
// rdm_pkg: widths, one-hot FSM encodings and the per-user config record
// shared by the RDM combine scheduler and its config table.
// No ports. Pure declarations plus a user-count clamp helper.
package rdm_pkg;

  localparam int E01_W     = 14;
  localparam int NCB_W     = 16;
  localparam int QM_W      = 2;
  localparam int USER_W    = 4;
  localparam int MAX_USERS = 16;
  localparam int CNT_W     = 5;   // user counter, holds 0..16
  localparam int TMO_W     = 16;
  localparam int ST_W      = 6;

  // One-hot scheduler states
  localparam logic [ST_W-1:0] ST_IDLE = 6'b000001;
  localparam logic [ST_W-1:0] ST_LOAD = 6'b000010;
  localparam logic [ST_W-1:0] ST_REQ  = 6'b000100;
  localparam logic [ST_W-1:0] ST_WAIT = 6'b001000;
  localparam logic [ST_W-1:0] ST_GAP  = 6'b010000;
  localparam logic [ST_W-1:0] ST_DONE = 6'b100000;

  // States during which the scheduler reports itself busy
  localparam logic [ST_W-1:0] ST_BUSY_MASK = ST_LOAD | ST_REQ | ST_WAIT | ST_GAP;

  typedef struct packed {
    logic [E01_W-1:0] e01;
    logic [NCB_W-1:0] ncb;
    logic [QM_W-1:0]  qm;
  } user_cfg_t;

  // Requested user count saturates at the table depth
  function automatic logic [CNT_W-1:0] clamp_users(input logic [CNT_W-1:0] n);
    if (n > CNT_W'(MAX_USERS)) begin
      return CNT_W'(MAX_USERS);
    end
    return n;
  endfunction

endpackage

// File: rtl/rdm_user_cfg_table.sv
// rdm_user_cfg_table: 16-entry per-user config register file (E01, Ncb, QM).
// Latency: write visible one cycle after the strobe; read port is combinational.
// Backpressure: none, writes are accepted every cycle.
// Ports: i_core_clk/i_rx_rstn clock and hard reset; i_wr_* write port;
//        i_rd_user/o_rd_* indexed read port; o_qm_flat all QM codes, user u at [2u+1:2u].
module rdm_user_cfg_table
  import rdm_pkg::*;
(
  input  logic                        i_core_clk,
  input  logic                        i_rx_rstn,
  input  logic                        i_wr_en,
  input  logic [USER_W-1:0]           i_wr_user,
  input  logic [E01_W-1:0]            i_wr_e01,
  input  logic [NCB_W-1:0]            i_wr_ncb,
  input  logic [QM_W-1:0]             i_wr_qm,
  input  logic [USER_W-1:0]           i_rd_user,
  output logic [E01_W-1:0]            o_rd_e01,
  output logic [NCB_W-1:0]            o_rd_ncb,
  output logic [MAX_USERS*QM_W-1:0]   o_qm_flat
);

  user_cfg_t                      r_tab [MAX_USERS];
  logic [MAX_USERS*QM_W-1:0]      w_qm_flat;

  // Only the hard reset clears the table; the scheduler soft reset must not.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      for (int u = 0; u < MAX_USERS; u++) begin
        r_tab[u] <= '0;
      end
    end else if (i_wr_en) begin
      r_tab[i_wr_user] <= {i_wr_e01, i_wr_ncb, i_wr_qm};
    end
  end

  assign o_rd_e01 = r_tab[i_rd_user].e01;
  assign o_rd_ncb = r_tab[i_rd_user].ncb;

  always_comb begin
    w_qm_flat = '0;
    for (int u = 0; u < MAX_USERS; u++) begin
      w_qm_flat[u*QM_W +: QM_W] = r_tab[u].qm;
    end
  end

  assign o_qm_flat = w_qm_flat;

endmodule

// File: rtl/rdm_combine_scheduler.sv
// rdm_combine_scheduler: walks up to 16 users per run, issuing one combine
// request per active user to the RDM data-supply FSM and pacing the users.
// Latency: start -> first request 2 cycles; completion -> next request GAP_CYC+2 cycles.
// Backpressure: one request in flight; waits for i_RDM_Data_Comp or TIMEOUT_CYC.
// Ports: i_core_clk, i_rx_rstn (hard), i_rx_fsm_rstn (soft, table kept);
//        i_sched_start/i_user_num run control; i_cfg_* table write port;
//        i_RDM_Data_Comp completion in; o_Combine_* request/index/sizes to RDM;
//        o_users_qm all QM codes; o_sched_busy/o_user_done/o_sched_done/o_timeout_err status.
module rdm_combine_scheduler
  import rdm_pkg::*;
#(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       i_core_clk,
  input  logic                       i_rx_rstn,
  input  logic                       i_rx_fsm_rstn,
  input  logic                       i_sched_start,
  input  logic [4:0]                 i_user_num,
  input  logic                       i_cfg_wr_en,
  input  logic [3:0]                 i_cfg_wr_user,
  input  logic [13:0]                i_cfg_e01_size,
  input  logic [15:0]                i_cfg_ncb_size,
  input  logic [1:0]                 i_cfg_qm,
  input  logic                       i_RDM_Data_Comp,
  output logic                       o_Combine_process_request,
  output logic [3:0]                 o_Combine_user_index,
  output logic [13:0]                o_Current_Combine_E01_Size,
  output logic [15:0]                o_Current_Combine_Ncb_Size,
  output logic [31:0]                o_users_qm,
  output logic                       o_sched_busy,
  output logic                       o_user_done,
  output logic                       o_sched_done,
  output logic                       o_timeout_err
);

  localparam int               GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [ST_W-1:0]   r_state;
  logic [CNT_W-1:0]  r_user_cnt;
  logic [CNT_W-1:0]  r_user_num;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_req;
  logic              r_user_done;
  logic              r_sched_done;
  logic              r_timeout_err;
  logic [USER_W-1:0] r_user_idx;
  logic [E01_W-1:0]  r_e01;
  logic [NCB_W-1:0]  r_ncb;

  logic              w_fsm_rstn;
  logic [CNT_W-1:0]  w_user_num_clamp;
  logic [CNT_W-1:0]  w_user_cnt_nxt;
  logic [E01_W-1:0]  w_rd_e01;
  logic [NCB_W-1:0]  w_rd_ncb;
  logic              w_start_acc;
  logic              w_tmo_hit;
  logic              w_tmo_fire;

  // Either reset clears the sequencing state; only i_rx_rstn reaches the table.
  assign w_fsm_rstn       = i_rx_rstn & i_rx_fsm_rstn;
  assign w_user_num_clamp = clamp_users(i_user_num);
  assign w_user_cnt_nxt   = r_user_cnt + CNT_W'(1);
  assign w_start_acc      = (r_state == ST_IDLE) && i_sched_start;
  // Counter restarts at 0 on entry to WAIT, so the last allowed cycle holds TIMEOUT_CYC-1.
  assign w_tmo_hit        = (r_tmo_cnt >= TMO_LAST);
  assign w_tmo_fire       = (r_state == ST_WAIT) && !i_RDM_Data_Comp && w_tmo_hit;

  rdm_user_cfg_table u_cfg_table (
    .i_core_clk (i_core_clk),
    .i_rx_rstn  (i_rx_rstn),
    .i_wr_en    (i_cfg_wr_en),
    .i_wr_user  (i_cfg_wr_user),
    .i_wr_e01   (i_cfg_e01_size),
    .i_wr_ncb   (i_cfg_ncb_size),
    .i_wr_qm    (i_cfg_qm),
    .i_rd_user  (r_user_cnt[USER_W-1:0]),
    .o_rd_e01   (w_rd_e01),
    .o_rd_ncb   (w_rd_ncb),
    .o_qm_flat  (o_users_qm)
  );

  always_ff @(posedge i_core_clk or negedge w_fsm_rstn) begin
    if (!w_fsm_rstn) begin
      r_state      <= ST_IDLE;
      r_user_cnt   <= '0;
      r_user_num   <= '0;
      r_gap_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_req        <= 1'b0;
      r_user_done  <= 1'b0;
      r_sched_done <= 1'b0;
      r_user_idx   <= '0;
      r_e01        <= '0;
      r_ncb        <= '0;
    end else begin
      r_req        <= 1'b0;
      r_user_done  <= 1'b0;
      r_sched_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_sched_start) begin
            r_user_cnt <= '0;
            r_user_num <= w_user_num_clamp;
            r_state    <= (w_user_num_clamp == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Sizes are latched here so they are stable a full cycle before the request.
          r_user_idx <= r_user_cnt[USER_W-1:0];
          r_e01      <= w_rd_e01;
          r_ncb      <= w_rd_ncb;
          r_gap_cnt  <= '0;
          if (w_rd_e01 == '0) begin
            r_user_done <= 1'b1;
            r_state     <= ST_GAP;
          end else begin
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_req     <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_RDM_Data_Comp || w_tmo_hit) begin
            r_user_done <= 1'b1;
            r_gap_cnt   <= '0;
            r_state     <= ST_GAP;
          end else if (r_tmo_cnt != '1) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ST_GAP: begin
          // Gap lets the RDM FSM return from DATACOMP to IDLE before the next request.
          if (r_gap_cnt == GAP_LAST) begin
            r_user_cnt <= w_user_cnt_nxt;
            r_state    <= (w_user_cnt_nxt == r_user_num) ? ST_DONE : ST_LOAD;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          r_sched_done <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error survives the soft reset so software can still see why a run stalled.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_timeout_err <= 1'b0;
    end else if (w_start_acc) begin
      r_timeout_err <= 1'b0;
    end else if (w_tmo_fire) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_Combine_process_request  = r_req;
  assign o_Combine_user_index       = r_user_idx;
  assign o_Current_Combine_E01_Size = r_e01;
  assign o_Current_Combine_Ncb_Size = r_ncb;
  assign o_sched_busy               = |(r_state & ST_BUSY_MASK);
  assign o_user_done                = r_user_done;
  assign o_sched_done               = r_sched_done;
  assign o_timeout_err              = r_timeout_err;

endmodule

// File: tb/tb_rdm_combine_scheduler.sv
// tb_rdm_combine_scheduler: directed bench for the combine scheduler.
// Expected requests come from a shadow config table pushed to a queue at start;
// a negedge monitor pops and compares on every request.
module tb_rdm_combine_scheduler;

  localparam int GAP_CYC  = 2;
  localparam int TMO_CYC  = 100;
  localparam int COMP_DLY = 50;

  logic        i_core_clk = 1'b0;
  logic        i_rx_rstn = 1'b0;
  logic        i_rx_fsm_rstn = 1'b1;
  logic        i_sched_start = 1'b0;
  logic [4:0]  i_user_num = '0;
  logic        i_cfg_wr_en = 1'b0;
  logic [3:0]  i_cfg_wr_user = '0;
  logic [13:0] i_cfg_e01_size = '0;
  logic [15:0] i_cfg_ncb_size = '0;
  logic [1:0]  i_cfg_qm = '0;
  logic        i_RDM_Data_Comp = 1'b0;
  logic        o_Combine_process_request;
  logic [3:0]  o_Combine_user_index;
  logic [13:0] o_Current_Combine_E01_Size;
  logic [15:0] o_Current_Combine_Ncb_Size;
  logic [31:0] o_users_qm;
  logic        o_sched_busy;
  logic        o_user_done;
  logic        o_sched_done;
  logic        o_timeout_err;

  rdm_combine_scheduler #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TMO_CYC)) dut (
    .i_core_clk                 (i_core_clk),
    .i_rx_rstn                  (i_rx_rstn),
    .i_rx_fsm_rstn              (i_rx_fsm_rstn),
    .i_sched_start              (i_sched_start),
    .i_user_num                 (i_user_num),
    .i_cfg_wr_en                (i_cfg_wr_en),
    .i_cfg_wr_user              (i_cfg_wr_user),
    .i_cfg_e01_size             (i_cfg_e01_size),
    .i_cfg_ncb_size             (i_cfg_ncb_size),
    .i_cfg_qm                   (i_cfg_qm),
    .i_RDM_Data_Comp            (i_RDM_Data_Comp),
    .o_Combine_process_request  (o_Combine_process_request),
    .o_Combine_user_index       (o_Combine_user_index),
    .o_Current_Combine_E01_Size (o_Current_Combine_E01_Size),
    .o_Current_Combine_Ncb_Size (o_Current_Combine_Ncb_Size),
    .o_users_qm                 (o_users_qm),
    .o_sched_busy               (o_sched_busy),
    .o_user_done                (o_user_done),
    .o_sched_done               (o_sched_done),
    .o_timeout_err              (o_timeout_err)
  );

  always #5 i_core_clk = ~i_core_clk;

  typedef struct {
    logic [3:0]  idx;
    logic [13:0] e01;
    logic [15:0] ncb;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] m_e01 [16];
  logic [15:0] m_ncb [16];
  logic [1:0]  m_qm  [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_req, n_user_done, n_sched_done;
  int start_cyc, first_req_cyc, req_cyc, comp_cyc, done_cyc, tmo_cyc;
  int last_idx;
  bit comp_seen = 1'b0;
  bit spacing_en = 1'b0;
  bit comp_en = 1'b1;
  logic        prev_err = 1'b0;
  logic [3:0]  prev_idx = '0;
  logic [13:0] prev_e01 = '0;
  logic [15:0] prev_ncb = '0;

  always @(posedge i_core_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_qm();
    logic [31:0] v;
    v = '0;
    for (int u = 0; u < 16; u++) v[2*u +: 2] = m_qm[u];
    return v;
  endfunction

  // Scoreboard side: every request is checked against the next expected user,
  // including the values held one cycle before the request.
  always @(negedge i_core_clk) begin
    exp_t e;
    if (o_Combine_process_request) begin
      n_req++;
      req_cyc  = cyc;
      last_idx = int'(o_Combine_user_index);
      if (n_req == 1) first_req_cyc = cyc;
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("req_idx", o_Combine_user_index, e.idx);
        chk("req_e01", o_Current_Combine_E01_Size, e.e01);
        chk("req_ncb", o_Current_Combine_Ncb_Size, e.ncb);
        chk("pre_req_idx", prev_idx, e.idx);
        chk("pre_req_e01", prev_e01, e.e01);
        chk("pre_req_ncb", prev_ncb, e.ncb);
      end
      chk("req_busy", o_sched_busy, 1);
      if (spacing_en && comp_seen) chk("req_spacing", cyc - comp_cyc, GAP_CYC + 2);
      comp_seen = 1'b0;
    end
    // Completion is high across the negedge before the edge that samples it.
    if (i_RDM_Data_Comp) begin
      comp_cyc  = cyc + 1;
      comp_seen = 1'b1;
    end
    if (o_user_done) n_user_done++;
    if (o_sched_done) begin
      n_sched_done++;
      done_cyc = cyc;
    end
    if (o_timeout_err && !prev_err) tmo_cyc = cyc;
    prev_err = o_timeout_err;
    prev_idx = o_Combine_user_index;
    prev_e01 = o_Current_Combine_E01_Size;
    prev_ncb = o_Current_Combine_Ncb_Size;
  end

  // RDM model: completion sampled COMP_DLY edges after the request edge.
  initial begin
    forever begin
      @(negedge i_core_clk);
      if (o_Combine_process_request && comp_en) begin
        repeat (COMP_DLY - 1) @(posedge i_core_clk);
        #1 i_RDM_Data_Comp = 1'b1;
        @(posedge i_core_clk);
        #1 i_RDM_Data_Comp = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic cfg_wr(input int u, input int e01, input int ncb, input int qm);
    i_cfg_wr_en    = 1'b1;
    i_cfg_wr_user  = 4'(u);
    i_cfg_e01_size = 14'(e01);
    i_cfg_ncb_size = 16'(ncb);
    i_cfg_qm       = 2'(qm);
    m_e01[u] = 14'(e01);
    m_ncb[u] = 16'(ncb);
    m_qm[u]  = 2'(qm);
    @(posedge i_core_clk); #1;
    i_cfg_wr_en = 1'b0;
  endtask

  task automatic push_user(input int u);
    exp_t e;
    e.idx = 4'(u);
    e.e01 = m_e01[u];
    e.ncb = m_ncb[u];
    sb.push_back(e);
  endtask

  task automatic clear_counts();
    n_req = 0; n_user_done = 0; n_sched_done = 0;
    comp_seen = 1'b0;
    sb.delete();
  endtask

  task automatic start_run(input int n);
    i_user_num    = 5'(n);
    i_sched_start = 1'b1;
    @(posedge i_core_clk); #1;
    i_sched_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_sched_done != 0) break;
      @(posedge i_core_clk); #1;
    end
    repeat (2) @(posedge i_core_clk);
    #1;
  endtask

  task automatic wait_req(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_req >= k) break;
      @(posedge i_core_clk); #1;
    end
  endtask

  task automatic soft_reset_check(input string tag);
    i_rx_fsm_rstn = 1'b0;
    #2;
    chk({tag, "_req"},  o_Combine_process_request, 0);
    chk({tag, "_busy"}, o_sched_busy, 0);
    chk({tag, "_idx"},  o_Combine_user_index, 0);
    chk({tag, "_e01"},  o_Current_Combine_E01_Size, 0);
    chk({tag, "_ncb"},  o_Current_Combine_Ncb_Size, 0);
    chk({tag, "_qm"},   o_users_qm, exp_qm());
    @(posedge i_core_clk); #1;
    i_rx_fsm_rstn = 1'b1;
    @(posedge i_core_clk); #1;
  endtask

  initial begin
    for (int u = 0; u < 16; u++) begin
      m_e01[u] = '0; m_ncb[u] = '0; m_qm[u] = '0;
    end
    clear_counts();

    // Reset state
    repeat (3) @(posedge i_core_clk);
    #1;
    chk("rst_req",   o_Combine_process_request, 0);
    chk("rst_idx",   o_Combine_user_index, 0);
    chk("rst_e01",   o_Current_Combine_E01_Size, 0);
    chk("rst_ncb",   o_Current_Combine_Ncb_Size, 0);
    chk("rst_qm",    o_users_qm, 0);
    chk("rst_busy",  o_sched_busy, 0);
    chk("rst_udone", o_user_done, 0);
    chk("rst_sdone", o_sched_done, 0);
    chk("rst_tmo",   o_timeout_err, 0);
    i_rx_rstn = 1'b1;
    @(posedge i_core_clk); #1;

    // Three users, completions 50 cycles after each request
    cfg_wr(0, 1024, 3000, 1);
    cfg_wr(1, 512, 1500, 2);
    cfg_wr(2, 2048, 6000, 3);
    chk("qm_flat", o_users_qm, exp_qm());
    clear_counts();
    spacing_en = 1'b1;
    push_user(0); push_user(1); push_user(2);
    start_run(3);
    chk("run_busy", o_sched_busy, 1);
    wait_done(1000);
    spacing_en = 1'b0;
    chk("t1_first_req_lat", first_req_cyc - start_cyc, 2);
    chk("t1_nreq", n_req, 3);
    chk("t1_udone", n_user_done, 3);
    chk("t1_sdone", n_sched_done, 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_idle_busy", o_sched_busy, 0);

    // Zero users: done pulse two cycles after start is driven, no request
    clear_counts();
    start_run(0);
    wait_done(50);
    chk("t2_done_lat", done_cyc - start_cyc, 1);
    chk("t2_sdone", n_sched_done, 1);
    chk("t2_nreq", n_req, 0);

    // 20 requested users clamp to 16
    for (int u = 3; u < 16; u++) cfg_wr(u, 100 + 10 * u, 2000 + u, u % 4);
    chk("t3_qm_flat", o_users_qm, exp_qm());
    clear_counts();
    for (int u = 0; u < 16; u++) push_user(u);
    start_run(20);
    wait_done(3000);
    chk("t3_nreq", n_req, 16);
    chk("t3_last_idx", last_idx, 15);
    chk("t3_sdone", n_sched_done, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // User 1 with E01=0 is skipped
    cfg_wr(1, 0, 1500, 2);
    clear_counts();
    push_user(0); push_user(2);
    start_run(3);
    wait_done(1000);
    chk("t4_nreq", n_req, 2);
    chk("t4_udone", n_user_done, 3);
    chk("t4_sdone", n_sched_done, 1);
    chk("t4_sb_empty", sb.size(), 0);
    cfg_wr(1, 512, 1500, 2);

    // Completion withheld: timeout after TMO_CYC cycles, scheduler moves on
    comp_en = 1'b0;
    clear_counts();
    push_user(0);
    start_run(1);
    wait_done(500);
    chk("t5_tmo_lat", tmo_cyc - req_cyc, TMO_CYC);
    chk("t5_tmo_flag", o_timeout_err, 1);
    chk("t5_udone", n_user_done, 1);
    chk("t5_sdone", n_sched_done, 1);
    soft_reset_check("t5_srst");
    chk("t5_tmo_kept", o_timeout_err, 1);
    comp_en = 1'b1;
    clear_counts();
    push_user(0);
    start_run(1);
    chk("t5_tmo_clear", o_timeout_err, 0);
    wait_done(500);
    chk("t5b_sdone", n_sched_done, 1);
    chk("t5b_tmo", o_timeout_err, 0);

    // Soft reset during user 2 wait; mid-run write to user 0 applies next run
    clear_counts();
    push_user(0); push_user(1); push_user(2);
    start_run(3);
    wait_req(1, 200);
    cfg_wr(0, 777, 4444, 0);
    wait_req(3, 500);
    chk("t6_nreq", n_req, 3);
    repeat (10) @(posedge i_core_clk);
    #1;
    soft_reset_check("t6_srst");
    repeat (60) @(posedge i_core_clk);
    #1;
    chk("t6_no_sdone", n_sched_done, 0);
    chk("t6_udone", n_user_done, 2);
    chk("t6_idle_busy", o_sched_busy, 0);
    clear_counts();
    push_user(0); push_user(1); push_user(2);
    start_run(3);
    wait_done(1000);
    chk("t6b_nreq", n_req, 3);
    chk("t6b_sdone", n_sched_done, 1);
    chk("t6b_sb_empty", sb.size(), 0);

    // Hard reset clears the table
    i_rx_rstn = 1'b0;
    #2;
    chk("hrst_qm", o_users_qm, 0);
    chk("hrst_idx", o_Combine_user_index, 0);
    @(posedge i_core_clk); #1;
    i_rx_rstn = 1'b1;
    @(posedge i_core_clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdm_combine_scheduler.md
# rdm_combine_scheduler

Sequences the RDM read/combine datapath across up to 16 users per scheduling run. It holds a per-user configuration table of E01 size, Ncb size and QM. For each active user it loads that user's sizes, issues a one-cycle combine request, waits for data-complete, observes an inter-user gap, then advances to the next user. It sits between the slot-level control logic and the RDM data-supply FSM, and it is the only source of that FSM's request, user index, size and QM inputs.

## Interface
- GAP_CYC, 2: idle cycles between a completion and the next request (minimum 2, covers the RDM DATACOMP→IDLE return).
- TIMEOUT_CYC, 65535: cycles allowed in WAIT_COMP before the user is abandoned.
- i_core_clk  in  1  core clock.
- i_rx_rstn  in  1  reset, asynchronous, active-low.
- i_rx_fsm_rstn  in  1  soft reset, asynchronous, active-low. Clears the FSM and counters only; the config table is kept.
- i_sched_start  in  1  start-of-run pulse.
- i_user_num  in  5  number of users this run (0..16; values above 16 are clamped to 16).
- i_cfg_wr_en  in  1  config table write strobe.
- i_cfg_wr_user  in  4  config table write index.
- i_cfg_e01_size  in  14  E01 size for that user.
- i_cfg_ncb_size  in  16  Ncb size for that user.
- i_cfg_qm  in  2  modulation order code for that user.
- i_RDM_Data_Comp  in  1  completion from the RDM FSM.
- o_Combine_process_request  out  1  one-cycle request to the RDM FSM.
- o_Combine_user_index  out  4  current user.
- o_Current_Combine_E01_Size  out  14  latched size of the current user.
- o_Current_Combine_Ncb_Size  out  16  latched size of the current user.
- o_users_qm  out  32  all 16 QM codes, 2 bits per user; user u occupies [2u+1:2u].
- o_sched_busy  out  1  high from LOAD through GAP.
- o_user_done  out  1  pulse on each completion or skip.
- o_sched_done  out  1  pulse at the end of a run.
- o_timeout_err  out  1  sticky; cleared by i_sched_start.

## Operation
- States: IDLE, LOAD, REQ, WAIT_COMP, GAP, DONE (one-hot).
- IDLE: on i_sched_start, set the user counter to 0 and latch N = min(i_user_num, 16).
  - N=0 → DONE.
  - N>0 → LOAD.
  - i_sched_start outside IDLE is ignored.
- LOAD: latch the table entry for the current user into the E01/Ncb outputs and drive the index.
  - E01 size = 0 → skip the user: pulse o_user_done and go to GAP with no request issued.
  - Otherwise → REQ.
- REQ: assert o_Combine_process_request for exactly 1 cycle → WAIT_COMP. Clear the timeout counter.
- WAIT_COMP: go to GAP on the first cycle i_RDM_Data_Comp=1, and pulse o_user_done.
  - If the timeout counter reaches TIMEOUT_CYC first: set o_timeout_err, then pulse i_rx_fsm_rstn-independent o_user_done and go to GAP. The user is abandoned.
- GAP: count GAP_CYC cycles. Then:
  - increment the user counter;
  - if counter = N → DONE, else → LOAD.
- DONE: pulse o_sched_done for 1 cycle → IDLE.
- Config writes are accepted in any state. Latched size outputs are not affected until the next LOAD.
  - A write to the current user mid-run takes effect only on a later run.
  - A write to a later user takes effect when that user loads.
- o_users_qm reflects the table continuously.
- Arithmetic: user counter 5 bits; timeout counter 16 bits, saturating; gap counter width $clog2(GAP_CYC+1).

## Timing
- Reset values:
  - all outputs 0;
  - table entries 0;
  - state IDLE.
- i_rx_fsm_rstn low: state → IDLE, counters cleared, request/busy/pulses forced to 0, latched outputs cleared to 0; table and o_timeout_err retained.
- Start sampled at edge 0:
  - LOAD at edge 1;
  - request high in cycle after edge 2;
  - index and sizes stable from edge 2, i.e. at least one cycle before and throughout the request.
- Completion at edge k → GAP from k+1 → next request GAP_CYC+2 cycles after k.
- Reset or soft-reset mid-run aborts without o_sched_done.
- i_RDM_Data_Comp high outside WAIT_COMP is ignored.

## Structure
- Shared package rdm_pkg holds:
  - state encodings;
  - widths E01_W=14, NCB_W=16, QM_W=2, USER_W=4, MAX_USERS=16.
- One sub-module: rdm_user_cfg_table.
  - 16-entry register file, 1 write port, 1 indexed read port, flattened QM bus.
  - Reset only by i_rx_rstn.

## Test plan
- Three users; E01 = 1024/512/2048; Ncb = 3000/1500/6000; comp returned 50 cycles after each request → 3 requests with indices 0,1,2 and matching sizes; o_sched_done once; requests spaced ≥ GAP_CYC+2 after each comp.
- i_user_num=0 → o_sched_done 2 cycles after start; no request issued.
- i_user_num=20, all 16 entries configured → exactly 16 requests; last index 15.
- User 1 has E01=0 → user 1 skipped (o_user_done pulse, no request); user 2 requested next.
- Comp withheld with TIMEOUT_CYC=100 → o_timeout_err set 100 cycles after the request; scheduler advances; next start clears the flag.
- i_rx_fsm_rstn pulsed during WAIT_COMP of user 2 → IDLE, outputs 0, table intact; restart yields the original sizes. Config write to user 0 during the run → visible on the next run only.
